// File: rtl/cmp_share_if.sv
// cmp_share_if - request/response bundle between the two comparator clients
// (port 0 = branch resolve, port 1 = set-less-than) and cmp_share_arbiter.
//   req_valid/req_ready  per-port request handshake (bit i = port i)
//   req_cmpop*/req_op*   per-port comparison opcode and operands
//   rsp_valid/rsp_ready  per-port response handshake
//   rsp_br_en            per-port registered comparison result
// Modports: master = requester side, slave = arbiter side.
interface cmp_share_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [2:0]  req_cmpop0;
  logic [31:0] req_op1_0;
  logic [31:0] req_op2_0;
  logic [2:0]  req_cmpop1;
  logic [31:0] req_op1_1;
  logic [31:0] req_op2_1;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [1:0]  rsp_br_en;

  modport master (
    output req_valid, req_cmpop0, req_op1_0, req_op2_0,
           req_cmpop1, req_op1_1, req_op2_1, rsp_ready,
    input  req_ready, rsp_valid, rsp_br_en
  );

  modport slave (
    input  req_valid, req_cmpop0, req_op1_0, req_op2_0,
           req_cmpop1, req_op1_1, req_op2_1, rsp_ready,
    output req_ready, rsp_valid, rsp_br_en
  );
endinterface

// File: rtl/cmp_share_arbiter.sv
// cmp_share_arbiter - shares one combinational branch comparator between two
// requesters with round-robin arbitration, one grant per cycle and one
// buffered response per port (latency 1).
// Ports:
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   bus           cmp_share_if.slave request/response bundle
//   cmp_op/a/b    operands to the shared comparator (granted port's fields)
//   cmp_br_en     comparator result, combinational in the same cycle
//   stat_issued   grants counted (only with CMP_STATS_EN, else tied 0)
//   stat_taken    grants whose result was 1 (only with CMP_STATS_EN, else 0)
// Build option: define CMP_STATS_EN to build the wrapping statistics counters.
//
// Arbiter state (rr):
//   state   | meaning
//   PREF_P0 | port 0 wins if both ports are eligible
//   PREF_P1 | port 1 wins if both ports are eligible
module cmp_share_arbiter #(
  parameter int STAT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  cmp_share_if.slave        bus,
  output logic [2:0]        cmp_op,
  output logic [31:0]       cmp_a,
  output logic [31:0]       cmp_b,
  input  logic              cmp_br_en,
  output logic [STAT_W-1:0] stat_issued,
  output logic [STAT_W-1:0] stat_taken
);

  typedef enum logic {PREF_P0 = 1'b0, PREF_P1 = 1'b1} rr_state_t;

  rr_state_t  rr_q, rr_d;
  logic [1:0] eligible;
  logic [1:0] grant;
  logic       gnt_port;
  logic [1:0] rsp_valid_q;
  logic [1:0] rsp_br_en_q;

  // A held (unconsumed) response blocks its port; a response being consumed
  // this cycle frees the slot for a back-to-back grant.
  assign eligible = bus.req_valid & (~rsp_valid_q | bus.rsp_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_q <= PREF_P0;
    else        rr_q <= rr_d;
  end

  always_comb begin
    grant    = 2'b00;
    rr_d     = rr_q;
    gnt_port = (rr_q == PREF_P1);
    // rst_n gates the grant so req_ready reads 0 throughout reset.
    if (rst_n) begin
      if (eligible == 2'b11) grant = (rr_q == PREF_P1) ? 2'b10 : 2'b01;
      else                   grant = eligible;
    end
    if (grant[1])      gnt_port = 1'b1;
    else if (grant[0]) gnt_port = 1'b0;
    if (|grant) rr_d = gnt_port ? PREF_P0 : PREF_P1;
  end

  // With no grant the mux still follows the preferred port (don't-care).
  always_comb begin
    cmp_op = bus.req_cmpop0;
    cmp_a  = bus.req_op1_0;
    cmp_b  = bus.req_op2_0;
    if (gnt_port) begin
      cmp_op = bus.req_cmpop1;
      cmp_a  = bus.req_op1_1;
      cmp_b  = bus.req_op2_1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 2'b00;
      rsp_br_en_q <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (grant[i]) begin
          rsp_valid_q[i] <= 1'b1;
          rsp_br_en_q[i] <= cmp_br_en;
        end else if (bus.rsp_ready[i]) begin
          rsp_valid_q[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.req_ready = grant;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_br_en = rsp_br_en_q;

`ifdef CMP_STATS_EN
  logic [STAT_W-1:0] issued_q;
  logic [STAT_W-1:0] taken_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_q <= '0;
      taken_q  <= '0;
    end else if (|grant) begin
      issued_q <= issued_q + STAT_W'(1);
      if (cmp_br_en) taken_q <= taken_q + STAT_W'(1);
    end
  end

  assign stat_issued = issued_q;
  assign stat_taken  = taken_q;
`else
  assign stat_issued = '0;
  assign stat_taken  = '0;
`endif

endmodule
